// File: rtl/mm_drain_pkg.sv
// Shared definitions for the mm result drain: FSM states, FP16 field constants.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_PACK = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  localparam int unsigned FP16_W      = 16;
  localparam int unsigned FP16_BIAS   = 15;
  localparam int unsigned FP16_MANT_W = 10;
  localparam logic [15:0] FP16_INF    = 16'h7C00;
  localparam int unsigned EXP_W       = 5;

  // Index width for n entries, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_drain_if.sv
// Bus between the mm array, the drain block and the FP16 result consumer.
interface mm_drain_if #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned N         = 2
);
  import mm_pkg::*;

  localparam int unsigned NE    = N * N;
  localparam int unsigned IDX_W = idx_width(NE);

  logic                     done;
  logic [NE*ACC_WIDTH-1:0]  acc_out;
  logic [NE*EXP_W-1:0]      exp_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [FP16_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;
  logic                     sat_flag;
  logic                     overrun;

  // Drain side
  modport master (
    input  done, acc_out, exp_out, out_ready,
    output out_valid, out_data, out_idx, out_last, busy, sat_flag, overrun
  );

  // Array / consumer side
  modport slave (
    output done, acc_out, exp_out, out_ready,
    input  out_valid, out_data, out_idx, out_last, busy, sat_flag, overrun
  );

endinterface

// File: rtl/mm_drain_acc2fp16.sv
// Fixed-point accumulator to FP16 converter, split into a normalise half and a
// pack half so the caller can put a register between them.
module acc2fp16
  import mm_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned EXP_BIAS  = 15,
  localparam int unsigned MAG_W    = ACC_WIDTH + 1,
  localparam int unsigned P_W      = $clog2(MAG_W)
) (
  // normalise half
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic                 o_sign_c,
  output logic [MAG_W-1:0]     o_mag_c,
  output logic [P_W-1:0]       o_p_c,
  // pack half
  input  logic                 i_sign,
  input  logic [MAG_W-1:0]     i_mag,
  input  logic [P_W-1:0]       i_p,
  input  logic [EXP_W-1:0]     i_exp,
  output logic [FP16_W-1:0]    o_fp16_c,
  output logic                 o_sat_c
);

  localparam int E_OFS = int'(FP16_BIAS) - int'(EXP_BIAS) - int'(FRAC_BITS);

  logic [MAG_W-1:0]       w_ext;
  logic [MAG_W-1:0]       w_mag;
  logic signed [31:0]     w_e;
  logic [FP16_MANT_W-1:0] w_mant;

  // Magnitude one bit wider than acc so the most-negative value stays exact
  always_comb begin
    w_ext    = {i_acc[ACC_WIDTH-1], i_acc};
    o_sign_c = i_acc[ACC_WIDTH-1];
    w_mag    = o_sign_c ? (~w_ext + MAG_W'(1)) : w_ext;
    o_mag_c  = w_mag;
  end

  // Leading-one position; highest set bit wins
  always_comb begin
    o_p_c = '0;
    for (int i = 0; i < int'(MAG_W); i++) begin
      if (w_mag[i]) o_p_c = P_W'(i);
    end
  end

  // Unbiased-to-FP16 exponent, wide and signed so it never wraps
  assign w_e = $signed(32'(i_p)) + $signed(32'(i_exp)) + 32'(E_OFS);

  // Mantissa: bits below the leading one, truncated or zero-padded
  always_comb begin
    if (i_p >= P_W'(FP16_MANT_W)) begin
      w_mant = FP16_MANT_W'(i_mag >> (i_p - P_W'(FP16_MANT_W)));
    end else begin
      w_mant = FP16_MANT_W'(i_mag << (P_W'(FP16_MANT_W) - i_p));
    end
  end

  // Final encode with zero, underflow-flush and overflow-to-inf cases
  always_comb begin
    o_fp16_c = '0;
    o_sat_c  = 1'b0;
    if (i_mag == '0) begin
      o_fp16_c = '0;
    end else if (w_e <= 32'sd0) begin
      o_fp16_c = {i_sign, 15'd0};
    end else if (w_e >= 32'sd31) begin
      o_fp16_c = {i_sign, FP16_INF[14:0]};
      o_sat_c  = 1'b1;
    end else begin
      o_fp16_c = {i_sign, w_e[4:0], w_mant};
    end
  end

endmodule

// File: rtl/mm_drain.sv
// Captures the mm array results on a done edge and streams them out one FP16
// entry at a time over a valid/ready handshake.
module mm_drain
  import mm_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned N         = 2,
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned EXP_BIAS  = 15
) (
  input  logic      clk,
  input  logic      rst,
  mm_drain_if.master bus
);

  localparam int unsigned NE    = N * N;
  localparam int unsigned IDX_W = idx_width(NE);
  localparam int unsigned MAG_W = ACC_WIDTH + 1;
  localparam int unsigned P_W   = $clog2(MAG_W);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_done_q;
  logic [ACC_WIDTH-1:0]  r_acc [NE];
  logic [EXP_W-1:0]      r_exp [NE];

  logic                  r_sign;
  logic [MAG_W-1:0]      r_mag;
  logic [P_W-1:0]        r_p;
  logic [EXP_W-1:0]      r_exp_n;

  logic                  r_out_valid;
  logic [FP16_W-1:0]     r_out_data;
  logic [IDX_W-1:0]      r_out_idx;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_sat;
  logic                  r_overrun;

  logic                  w_sign;
  logic [MAG_W-1:0]      w_mag;
  logic [P_W-1:0]        w_p;
  logic [FP16_W-1:0]     w_fp16;
  logic                  w_sat;
  logic                  w_done_rise;
  logic                  w_last_idx;

  assign w_done_rise = bus.done && !r_done_q;
  assign w_last_idx  = (r_idx == IDX_W'(NE - 1));

  // Shared converter: normalise half fed from capture, pack half from NORM regs
  acc2fp16 #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .EXP_BIAS  (EXP_BIAS)
  ) u_conv (
    .i_acc    (r_acc[r_idx]),
    .o_sign_c (w_sign),
    .o_mag_c  (w_mag),
    .o_p_c    (w_p),
    .i_sign   (r_sign),
    .i_mag    (r_mag),
    .i_p      (r_p),
    .i_exp    (r_exp_n),
    .o_fp16_c (w_fp16),
    .o_sat_c  (w_sat)
  );

  // Drain FSM with capture, per-entry pipeline registers and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_done_q    <= 1'b0;
      for (int l = 0; l < int'(NE); l++) begin
        r_acc[l] <= '0;
        r_exp[l] <= '0;
      end
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_p         <= '0;
      r_exp_n     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done_q <= bus.done;

      // A done edge while draining is dropped but remembered
      if (w_done_rise && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_done_rise) begin
            for (int l = 0; l < int'(NE); l++) begin
              r_acc[l] <= bus.acc_out[l*ACC_WIDTH +: ACC_WIDTH];
              r_exp[l] <= bus.exp_out[l*EXP_W +: EXP_W];
            end
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_sign  <= w_sign;
          r_mag   <= w_mag;
          r_p     <= w_p;
          r_exp_n <= r_exp[r_idx];
          r_state <= ST_PACK;
        end
        ST_PACK: begin
          r_out_data  <= w_fp16;
          r_out_idx   <= r_idx;
          r_out_last  <= w_last_idx;
          r_out_valid <= 1'b1;
          if (w_sat) r_sat <= 1'b1;
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_idx) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_NORM;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;
  assign bus.sat_flag  = r_sat;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_mm_drain.sv
// Self-checking bench for mm_drain: vector table plus scoreboard monitor,
// with hand sequences for backpressure, overrun and mid-drain reset.
module tb_mm_drain;
  import mm_pkg::*;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned N     = 2;
  localparam int unsigned NE    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mm_drain_if #(.ACC_WIDTH(ACC_W), .N(N)) bus ();

  mm_drain #(
    .ACC_WIDTH (ACC_W),
    .N         (N),
    .FRAC_BITS (10),
    .EXP_BIAS  (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [NE-1:0][31:0] acc;
    logic [NE-1:0][4:0]  ex;
    logic [NE-1:0][15:0] res;
    logic                sat;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3,
                              input logic [4:0] e0, e1, e2, e3,
                              input logic [15:0] r0, r1, r2, r3,
                              input logic s);
    vec_t v;
    v.acc[0] = a0; v.acc[1] = a1; v.acc[2] = a2; v.acc[3] = a3;
    v.ex[0]  = e0; v.ex[1]  = e1; v.ex[2]  = e2; v.ex[3]  = e3;
    v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
    v.sat    = s;
    return v;
  endfunction

  // Scoreboard: every accepted output is popped and compared
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: idx %0d data %h with nothing expected", bus.out_idx, bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("out_data[%0d]", e.idx), 32'(bus.out_data), 32'(e.data));
        chk($sformatf("out_idx[%0d]", e.idx), 32'(bus.out_idx), 32'(e.idx));
        chk($sformatf("out_last[%0d]", e.idx), 32'(bus.out_last), 32'(e.last));
        if (e.idx != 2'd0) chk($sformatf("spacing[%0d]", e.idx), 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
      end
    end
  end

  task automatic load(input vec_t v);
    logic [NE*32-1:0] a;
    logic [NE*5-1:0]  e;
    for (int l = 0; l < int'(NE); l++) begin
      a[l*32 +: 32] = v.acc[l];
      e[l*5 +: 5]   = v.ex[l];
    end
    bus.acc_out = a;
    bus.exp_out = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Load, queue expectations, pulse done, check first-valid latency, scramble inputs
  task automatic start_vec(input vec_t v);
    exp_t e;
    load(v);
    for (int l = 0; l < int'(NE); l++) begin
      e.data = v.res[l];
      e.idx  = 2'(l);
      e.last = (l == int'(NE) - 1);
      sb.push_back(e);
    end
    @(posedge clk); #1 bus.done = 1'b1;
    @(posedge clk); #1 bus.done = 1'b0;
    bus.acc_out = {$urandom, $urandom, $urandom, $urandom};
    bus.exp_out = 20'($urandom);
    @(negedge clk);
    chk("busy_after_capture", 32'(bus.busy), 32'd1);
    chk("valid_cap+1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("valid_cap+1b", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("valid_cap+2", 32'(bus.out_valid), 32'd1);
    chk("first_idx", 32'(bus.out_idx), 32'd0);
  endtask

  task automatic finish_vec(input vec_t v);
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries still pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("busy_after_last", 32'(bus.busy), 32'd0);
    chk("valid_after_last", 32'(bus.out_valid), 32'd0);
    chk("sat_flag", 32'(bus.sat_flag), 32'(v.sat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.done      = 1'b0;
    bus.out_ready = 1'b1;
    bus.acc_out   = '0;
    bus.exp_out   = '0;

    vecs[0] = mk(32'hFFFFD800, 32'hFFFFF400, 32'hFFFFD800, 32'hFFFFF000,
                 5'd15, 5'd15, 5'd15, 5'd15,
                 16'hC900, 16'hC200, 16'hC900, 16'hC400, 1'b0);
    vecs[1] = mk(32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000400,
                 5'd31, 5'd0, 5'd0, 5'd15,
                 16'h7C00, 16'h0000, 16'h0000, 16'h3C00, 1'b1);
    vecs[2] = mk(32'h80000000, 32'h00000000, 32'h00000400, 32'hFFFFFC00,
                 5'd0, 5'd7, 5'd15, 5'd15,
                 16'hD400, 16'h0000, 16'h3C00, 16'hBC00, 1'b0);
    vecs[3] = mk(32'h00000001, 32'h00000003, 32'h7FFFFFFF, 32'hFFFFFFFF,
                 5'd25, 5'd20, 5'd0, 5'd10,
                 16'h3C00, 16'h2E00, 16'h53FF, 16'h8000, 1'b0);
    vecs[4] = mk(32'h00000400, 32'hFFFFF800, 32'h00000000, 32'h00000002,
                 5'd30, 5'd30, 5'd31, 5'd9,
                 16'h7800, 16'hFC00, 16'h0000, 16'h0000, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sat", 32'(bus.sat_flag), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;

    // Table-driven drains, out_ready held high
    for (int i = 0; i < 5; i++) begin
      do_reset();
      start_vec(vecs[i]);
      finish_vec(vecs[i]);
      chk($sformatf("overrun_vec%0d", i), 32'(bus.overrun), 32'd0);
    end

    // Backpressure on the first entry
    do_reset();
    bus.out_ready = 1'b0;
    start_vec(vecs[0]);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'h0000C900);
      chk("bp_idx", 32'(bus.out_idx), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    finish_vec(vecs[0]);

    // Overrun: done re-pulsed during SEND of idx 1
    do_reset();
    start_vec(vecs[0]);
    for (int k = 0; k < 20 && !(bus.out_valid && bus.out_idx == 1'b1); k++) @(negedge clk);
    chk("ovr_reach_idx1", 32'(bus.out_valid && bus.out_idx == 1'b1), 32'd1);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    finish_vec(vecs[0]);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    repeat (10) @(negedge clk);
    chk("ovr_no_extra_busy", 32'(bus.busy), 32'd0);
    start_vec(vecs[0]);
    finish_vec(vecs[0]);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Reset after the idx-1 handshake of a saturating drain with overrun set
    do_reset();
    start_vec(vecs[4]);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    for (int k = 0; k < 30 && sb.size() > 2; k++) @(negedge clk);
    chk("mid_pending", 32'(sb.size()), 32'd2);
    chk("mid_sat_before", 32'(bus.sat_flag), 32'd1);
    chk("mid_ovr_before", 32'(bus.overrun), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_sat", 32'(bus.sat_flag), 32'd0);
    chk("mid_rst_ovr", 32'(bus.overrun), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_idle_valid", 32'(bus.out_valid), 32'd0);
    start_vec(vecs[0]);
    finish_vec(vecs[0]);
    chk("mid_restart_ovr", 32'(bus.overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_drain.md
MM_DRAIN -- requirements
Module: mm_drain

Interface
REQ-001 Parameters SHALL be:
- ACC_WIDTH, default 32, accumulator width per PE.
- N, default 2, array dimension (N*N results).
- FRAC_BITS, default 10, fractional bits of the accumulator.
- EXP_BIAS, default 15, bias of exp_out.

REQ-002 Ports SHALL be:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- done, in, 1: completion strobe from the mm array.
- acc_out, in, N*N*ACC_WIDTH: flattened signed results; entry l = row*N+col at bits [l*ACC_WIDTH +: ACC_WIDTH].
- exp_out, in, N*N*5: flattened per-PE exponents, entry l at [l*5 +: 5].
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: consumer accepts.
- out_data, out, 16: FP16 result.
- out_idx, out, clog2(N*N) (min 1): entry index of out_data.
- out_last, out, 1: high with out_valid on entry N*N-1.
- busy, out, 1: a drain is in progress.
- sat_flag, out, 1: sticky, set when any entry overflowed.
- overrun, out, 1: sticky, set when done rose while busy.

Function
REQ-003 Each entry SHALL be converted from value = signed(acc) x 2^(exp - EXP_BIAS - FRAC_BITS) to IEEE FP16.
REQ-004 Conversion SHALL take sign = acc MSB and mag = |acc| computed at ACC_WIDTH+1 bits, so that the most-negative acc is exact.
REQ-005 With p = leading-one position of mag, the FP16 exponent SHALL be e = p + exp - EXP_BIAS - FRAC_BITS + 15, evaluated signed with no wrap.
REQ-006 The mantissa SHALL be the 10 bits below the leading one, truncated toward zero, zero-padded when p < 10.
REQ-007 Boundary cases SHALL resolve as follows:
- mag = 0: output 0x0000.
- e <= 0: output sign<<15 (flush to signed zero).
- e >= 31: output sign<<15 | 0x7C00, and set sat_flag.
REQ-008 The FSM SHALL have states IDLE, NORM, PACK and SEND.
REQ-009 In IDLE, when done is sampled high with the registered done_q low, the block SHALL capture all acc_out/exp_out into internal registers, set idx=0, and go to NORM.
REQ-010 NORM SHALL register mag, sign, p and exp of entry idx, then go to PACK.
REQ-011 PACK SHALL register out_data, out_idx and out_last, assert out_valid, and go to SEND.
REQ-012 First out_valid SHALL therefore rise 2 clocks after the capture edge; throughput is one entry per 3 clocks when out_ready is held high.
REQ-013 In SEND, out_data, out_idx and out_last SHALL stay stable until out_valid && out_ready.
REQ-014 On that handshake, out_valid SHALL drop; the block then goes to IDLE if idx = N*N-1, else increments idx and goes to NORM.
REQ-015 busy SHALL be high in every state except IDLE.
REQ-016 done_q SHALL update every cycle. A done rising edge in a non-IDLE state SHALL be ignored and SHALL set overrun; this includes the edge of the final handshake.
REQ-017 Input changes after capture SHALL NOT affect the drain in progress.

Reset
REQ-018 While rst is high, the block SHALL hold state IDLE, idx=0, done_q=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, sat_flag=0, overrun=0, and clear the capture registers.
REQ-019 A reset mid-drain SHALL discard all pending entries. The next done edge after release SHALL restart from idx 0.

Structure
REQ-020 A shared package mm_pkg SHALL hold the state enum, FP16 constants (bias 15, INF 0x7C00, mantissa width 10) and the exp field width 5.
REQ-021 The conversion datapath SHALL be one sub-module acc2fp16, combinational, used as two registered halves (NORM and PACK). The FSM and capture logic SHALL live in mm_drain.

Verification
REQ-022 Nominal: acc = {FFFFD800, FFFFF400, FFFFD800, FFFFF000}, exp all 15, out_ready=1. Required: out_data C900, C200, C900, C400 with idx 0..3; out_last only on idx 3; busy low after the 4th handshake.
REQ-023 Backpressure: out_ready=0 for 5 cycles after the first valid. Required: out_data=C900 and idx=0 held stable; the sequence resumes unchanged.
REQ-024 Range: single-entry checks.
- acc=0x7FFFFFFF, exp=31: 0x7C00 and sat_flag=1.
- acc=1, exp=0: 0x0000.
- acc=0: 0x0000.
- acc=0x00000400, exp=15: 0x3C00.
REQ-025 Most-negative: acc=0x80000000, exp=0 -> 0xD400, and sat_flag stays 0.
REQ-026 Overrun: done re-pulsed during SEND of idx 1. Required: overrun=1 and output sequence unchanged; after the sequence ends, a fresh done edge drains again from idx 0.
REQ-027 Reset mid-drain: assert rst after the idx-1 handshake. Required: out_valid, busy, sat_flag and overrun all 0 immediately; a subsequent done restarts at idx 0.
